// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder arbiter.
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Width of the nibble index counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/adder4_slice.sv
// One 4-bit full-adder slice, purely combinational.
module adder4_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_adder_arbiter.sv
// Two requesters share one 4-bit adder slice; wide adds run nibble-serially
// with a registered carry, and requesters are served round-robin.
module nibble_adder_arbiter
  import nibble_adder_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         busy
);

  localparam int unsigned     IdxW    = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic            carry_q, carry_d, id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic            cout_q, cout_d, rsp_id_q, rsp_id_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [NIBBLE_W-1:0] sl_a, sl_b, sl_s;
  logic                sl_co;
  logic [IdxW+1:0]     base;
  logic [W-1:0]        acc_ins;
  logic                idle, grant0, grant1;

  assign idle   = (state_q == StIdle);
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
  assign grant1 = req1_valid & (~req0_valid | rr_ptr_q);
  // Gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n & idle & grant0;
  assign req1_ready = rst_n & idle & grant1;

  // Bit offset of the active nibble.
  assign base = {idx_q, 2'b00};
  assign sl_a = a_q[base +: NIBBLE_W];
  assign sl_b = b_q[base +: NIBBLE_W];

  adder4_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Partial sum with the current slice result merged in.
  always_comb begin
    acc_ins = acc_q;
    acc_ins[base +: NIBBLE_W] = sl_s;
  end

  // Next-state: arbitration in idle, one nibble per edge in add.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    rsp_id_d = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (req0_ready || req1_ready) begin
          id_d     = req1_ready;
          a_d      = req1_ready ? req1_a : req0_a;
          b_d      = req1_ready ? req1_b : req0_b;
          carry_d  = req1_ready ? req1_cin : req0_cin;
          acc_d    = '0;
          idx_d    = '0;
          rr_ptr_d = ~req1_ready;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        acc_d   = acc_ins;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d    = '0;
          sum_d    = acc_ins;
          cout_d   = sl_co;
          rsp_id_d = id_q;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= 1'b0;
      rr_ptr_q <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign busy      = ~idle;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/nibble_adder_arbiter.md
Name: nibble_adder_arbiter

Overview:
- Shares one 4-bit full-adder slice between two requesters.
- Each request is a wide add (4*NIBBLES bits plus carry-in), executed nibble-serially through the slice with a registered carry.
- Round-robin arbitration between the requesters; valid/ready on requests, one-cycle pulse on the response.
- Sits between the 4-bit ripple adder datapath and the upstream blocks that need wide adds without replicating adders.

Parameters:
- NIBBLES, 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range is 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted at this edge.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  output  1  one-cycle result pulse.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_sum  output  W  (A+B+cin) mod 2^W.
- rsp_cout  output  1  carry out of the MSB nibble.
- busy  output  1  high while state is not IDLE.

Behaviour:
- States are IDLE, ADD and DONE. The state, operand regs, carry reg, nibble index, rr_ptr and all registered outputs reset asynchronously on rst_n low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, rr_ptr=0 (requester 0 has priority), state=IDLE.
- reqX_ready is combinational. It is 1 only when state is IDLE, reqX_valid=1 and X is granted. It is never 1 in ADD or DONE.
- Grant rules in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by rr_ptr is granted.
  - On every accept, rr_ptr is set to the other requester.
- Accept edge (valid and ready): latch A, B, cin and id; carry register = cin; nibble index = 0; go to ADD.
- ADD: each edge processes nibble k through the slice.
  - Result nibble k = A[4k+3:4k] + B[4k+3:4k] + carry.
  - Carry register takes the slice carry-out; k increments.
  - On the edge that processes nibble NIBBLES-1: state goes to DONE, and rsp_sum, rsp_cout and rsp_id are updated.
- DONE lasts one cycle with rsp_valid=1, then returns to IDLE. rsp_valid is 0 in all other states.
- Latency: rsp_valid is high in the cycle after the NIBBLES-th edge following the accept edge.
- Throughput: the earliest next accept is NIBBLES+2 edges after the previous accept.
- rsp_sum, rsp_cout and rsp_id hold their values until the next DONE or until reset.
- Operand changes on the request ports after acceptance have no effect.
- A requester dropping valid in IDLE before acceptance is legal; nothing is latched.
- Reset asserted mid-ADD or in DONE:
  - All outputs clear immediately.
  - The operation is discarded and no rsp_valid is produced.
  - rr_ptr returns to 0.
- Overflow wraps modulo 2^W; the carry is reported only via rsp_cout.

Decomposition:
- Package nibble_adder_pkg:
  - state enum {IDLE, ADD, DONE};
  - constant NIBBLE_W=4;
  - helper function for index width, clog2(NIBBLES) with a minimum of 1.
- Sub-module adder4_slice: purely combinational, inputs a[3:0], b[3:0], ci; outputs s[3:0], co.
- Instantiate adder4_slice once; the controller muxes the active nibble into it.

Test Plan:
1. Reset behaviour: hold rst_n=0 with both valids high -> all outputs 0, both readys 0. Release reset -> req0_ready=1 in the first IDLE cycle.
2. Single request: req0 a=16'h1234, b=16'h4321, cin=0 -> rsp_sum=16'h5555, rsp_cout=0, rsp_id=0. rsp_valid is high for exactly one cycle, after the 4th edge following accept.
3. Full carry ripple: req1 a=16'hFFFF, b=16'h0000, cin=1 -> rsp_sum=16'h0000, rsp_cout=1, rsp_id=1. Also a=16'h0001, b=16'hFFFF, cin=0 -> 16'h0000, cout=1.
4. Arbitration: both valid continuously from reset with distinct operands -> rsp_id sequence 0,1,0,1. Accepts spaced 6 edges apart. Operands latched correctly per id.
5. Reset mid-operation: assert rst_n=0 after 2 ADD edges -> outputs 0 immediately, no rsp_valid. Next req1-only request then returns the correct result with rsp_id=1.
6. NIBBLES=1 build: a=4'hF, b=4'h1, cin=0 -> rsp_sum=4'h0, rsp_cout=1. rsp_valid is high in the cycle after the first edge following accept.
